// File: rtl/tick_event_sequencer.sv
// -----------------------------------------------------------------------------
// tick_event_sequencer
//
// Turns the fixed-rate one-hot tick from the ring counter into a programmable,
// handshaked event stream. Rising edges of TICK are counted up to a period
// latched at START. When the period elapses an event is raised on REQ and held
// until ACK. In one-shot mode the sequence ends at the first ACK; in continuous
// mode it keeps running. If a period elapses while REQ is still pending, the
// event is dropped and OVERRUN is flagged.
//
// State table:
//   state    | meaning
//   IDLE     | not armed; waiting for START
//   RUN      | counting tick edges towards the next event
//   WAIT_ACK | event raised on REQ, waiting for ACK; ticks still counted
//
// Ports:
//   CK       in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   TICK     in   periodic pulse from ring counter
//   START    in   one-cycle arm request (PERIOD and CONT sampled here)
//   STOP     in   abort to IDLE, beats START and ACK
//   CONT     in   1 = continuous, 0 = one-shot
//   PERIOD   in   ticks per event, 0 is rejected with ERR
//   ACK      in   consumer acknowledge of REQ
//   BUSY     out  high in RUN or WAIT_ACK
//   REQ      out  event request, held until ACK
//   DONE     out  one-cycle pulse at end of a one-shot sequence
//   ERR      out  one-cycle pulse when START is given with PERIOD == 0
//   OVERRUN  out  sticky, cleared by the next accepted START
//   EVT_CNT  out  events fired, wraps silently
// -----------------------------------------------------------------------------
module tick_event_sequencer #(
  parameter int C_PERIOD_W = 8,
  parameter int C_EVT_W    = 16
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CONT,
  input  logic [C_PERIOD_W-1:0] PERIOD,
  input  logic                  ACK,
  output logic                  BUSY,
  output logic                  REQ,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  OVERRUN,
  output logic [C_EVT_W-1:0]    EVT_CNT
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  localparam logic [C_PERIOD_W-1:0] P_ZERO = '0;
  localparam logic [C_PERIOD_W-1:0] P_ONE  = C_PERIOD_W'(1);
  localparam logic [C_EVT_W-1:0]    E_ONE  = C_EVT_W'(1);

  state_t                  state_q,   state_n;
  logic                    tick_d;
  logic [C_PERIOD_W-1:0]   tick_cnt_q, tick_cnt_n;
  logic [C_PERIOD_W-1:0]   period_q,   period_n;
  logic                    cont_q,     cont_n;
  logic                    req_q,      req_n;
  logic                    done_q,     done_n;
  logic                    err_q,      err_n;
  logic                    ovr_q,      ovr_n;
  logic [C_EVT_W-1:0]      evt_q,      evt_n;

  logic                    tick_edge;
  logic                    expire;
  logic [C_PERIOD_W-1:0]   period_last;

  // tick_d clears on reset, so a TICK already high right after release is
  // seen as a fresh edge.
  assign tick_edge   = TICK & ~tick_d;
  assign period_last = period_q - P_ONE;
  assign expire      = tick_edge && (tick_cnt_q == period_last);

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tick_d     <= 1'b0;
      tick_cnt_q <= '0;
      period_q   <= '0;
      cont_q     <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      evt_q      <= '0;
    end else begin
      state_q    <= state_n;
      tick_d     <= TICK;
      tick_cnt_q <= tick_cnt_n;
      period_q   <= period_n;
      cont_q     <= cont_n;
      req_q      <= req_n;
      done_q     <= done_n;
      err_q      <= err_n;
      ovr_q      <= ovr_n;
      evt_q      <= evt_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    tick_cnt_n = tick_cnt_q;
    period_n   = period_q;
    cont_n     = cont_q;
    req_n      = req_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    ovr_n      = ovr_q;
    evt_n      = evt_q;

    if (STOP) begin
      // Abort keeps OVERRUN and the tally so the controller can inspect them.
      state_n    = S_IDLE;
      req_n      = 1'b0;
      tick_cnt_n = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (PERIOD == P_ZERO) begin
              err_n = 1'b1;
            end else begin
              // A tick edge coinciding with START is deliberately not counted.
              period_n   = PERIOD;
              cont_n     = CONT;
              tick_cnt_n = '0;
              ovr_n      = 1'b0;
              state_n    = S_RUN;
            end
          end
        end

        S_RUN: begin
          if (expire) begin
            tick_cnt_n = '0;
            req_n      = 1'b1;
            evt_n      = evt_q + E_ONE;
            state_n    = S_WAIT_ACK;
          end else if (tick_edge) begin
            tick_cnt_n = tick_cnt_q + P_ONE;
          end
        end

        S_WAIT_ACK: begin
          if (ACK) begin
            if (cont_q) begin
              if (expire) begin
                // ACK and expiry together: the old event is retired and the
                // expiring tick fires the next one, so REQ never drops.
                tick_cnt_n = '0;
                evt_n      = evt_q + E_ONE;
              end else begin
                req_n   = 1'b0;
                state_n = S_RUN;
                if (tick_edge) begin
                  tick_cnt_n = tick_cnt_q + P_ONE;
                end
              end
            end else begin
              req_n      = 1'b0;
              done_n     = 1'b1;
              tick_cnt_n = '0;
              state_n    = S_IDLE;
            end
          end else if (expire) begin
            // Period elapsed with the previous event still pending: drop it.
            ovr_n      = 1'b1;
            tick_cnt_n = '0;
          end else if (tick_edge) begin
            tick_cnt_n = tick_cnt_q + P_ONE;
          end
        end

        default: begin
          state_n    = S_IDLE;
          req_n      = 1'b0;
          tick_cnt_n = '0;
        end
      endcase
    end
  end

  assign BUSY    = (state_q != S_IDLE);
  assign REQ     = req_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign OVERRUN = ovr_q;
  assign EVT_CNT = evt_q;

endmodule

// File: tb/tb_tick_event_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tick_event_sequencer
//
// Directed bench for tick_event_sequencer. The event tally is built 4 bits
// wide so the wrap from 15 to 0 is reachable quickly. TICK is generated every
// 4 clocks unless a test drives it by hand.
// -----------------------------------------------------------------------------
module tb_tick_event_sequencer;

  logic       CK;
  logic       RST;
  logic       TICK;
  logic       START;
  logic       STOP;
  logic       CONT;
  logic [7:0] PERIOD;
  logic       ACK;
  logic       BUSY;
  logic       REQ;
  logic       DONE;
  logic       ERR;
  logic       OVERRUN;
  logic [3:0] EVT_CNT;

  int checks   = 0;
  int failures = 0;
  int ph       = 0;
  bit tick_auto = 1'b0;

  tick_event_sequencer #(
    .C_PERIOD_W(8),
    .C_EVT_W   (4)
  ) dut (
    .CK     (CK),
    .RST    (RST),
    .TICK   (TICK),
    .START  (START),
    .STOP   (STOP),
    .CONT   (CONT),
    .PERIOD (PERIOD),
    .ACK    (ACK),
    .BUSY   (BUSY),
    .REQ    (REQ),
    .DONE   (DONE),
    .ERR    (ERR),
    .OVERRUN(OVERRUN),
    .EVT_CNT(EVT_CNT)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable and inputs may be changed on return.
  task automatic step();
    @(posedge CK);
    #1;
    ph = (ph + 1) % 4;
    if (tick_auto) TICK = (ph == 0);
  endtask

  // Run until a tick is presented, then let the clock sample it.
  task automatic tick_sampled(input string tag);
    int n = 0;
    while (!TICK && n < 20) begin
      step();
      n++;
    end
    if (!TICK) check(tag, 0, 1);
    step();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!REQ && n < 100) begin
      step();
      n++;
    end
    if (!REQ) check(tag, 0, 1);
  endtask

  task automatic start_seq(input logic [7:0] p, input logic c);
    START  = 1'b1;
    PERIOD = p;
    CONT   = c;
    step();
    START  = 1'b0;
  endtask

  task automatic stop_seq();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
  endtask

  initial begin
    int nreq;
    int last;
    int cyc;
    logic prev;

    RST = 1'b1; TICK = 1'b0; START = 1'b0; STOP = 1'b0;
    CONT = 1'b0; PERIOD = 8'd0; ACK = 1'b0;
    step();
    step();
    check("rst_busy", BUSY, 0);
    check("rst_req", REQ, 0);
    check("rst_ovr", OVERRUN, 0);
    RST = 1'b0;
    tick_auto = 1'b1;

    // Idle with ticks running and no START.
    for (int i = 0; i < 12; i++) begin
      step();
      check("idle_busy", BUSY, 0);
      check("idle_req", REQ, 0);
      check("idle_evt", EVT_CNT, 0);
    end

    // One-shot, PERIOD=3.
    start_seq(8'd3, 1'b0);
    check("os_busy", BUSY, 1);
    tick_sampled("os_t1");
    tick_sampled("os_t2");
    cyc = 0;
    while (!TICK && cyc < 20) begin
      step();
      cyc++;
    end
    check("os_req_before", REQ, 0);
    step();
    check("os_req_latency", REQ, 1);
    check("os_evt", EVT_CNT, 1);
    step();
    step();
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    check("os_req_clr", REQ, 0);
    check("os_done", DONE, 1);
    check("os_idle", BUSY, 0);
    check("os_evt_after", EVT_CNT, 1);
    step();
    check("os_done_pulse", DONE, 0);

    // Continuous, PERIOD=2, ACK one cycle after each REQ.
    start_seq(8'd2, 1'b1);
    nreq = 0; last = 0; cyc = 0; prev = 1'b0;
    while (cyc < 100 && !(nreq == 5 && !REQ)) begin
      if (REQ && !prev) begin
        if (nreq > 0) check("cont_gap", cyc - last, 8);
        last = cyc;
        nreq++;
      end
      prev = REQ;
      ACK  = REQ;
      step();
      cyc++;
    end
    ACK = 1'b0;
    check("cont_nreq", nreq, 5);
    check("cont_evt", EVT_CNT, 6);
    check("cont_ovr", OVERRUN, 0);
    stop_seq();
    check("cont_stop_idle", BUSY, 0);

    // Overrun: ACK withheld for 3 periods.
    start_seq(8'd2, 1'b1);
    wait_req("ovr_req_timeout");
    check("ovr_pre", OVERRUN, 0);
    check("ovr_evt_first", EVT_CNT, 7);
    for (int i = 0; i < 6; i++) tick_sampled("ovr_tick");
    check("ovr_flag", OVERRUN, 1);
    check("ovr_req_held", REQ, 1);
    check("ovr_evt", EVT_CNT, 7);

    // ACK coincident with expiry.
    tick_sampled("col_t1");
    cyc = 0;
    while (!TICK && cyc < 20) begin
      step();
      cyc++;
    end
    ACK = 1'b1;
    step();
    ACK = 1'b0;
    check("col_req", REQ, 1);
    check("col_evt", EVT_CNT, 8);
    check("col_ovr", OVERRUN, 1);
    check("col_busy", BUSY, 1);

    stop_seq();
    check("stop_keeps_ovr", OVERRUN, 1);
    check("stop_req", REQ, 0);
    start_seq(8'd2, 1'b1);
    check("start_clr_ovr", OVERRUN, 0);
    stop_seq();

    // PERIOD=0 rejected.
    start_seq(8'd0, 1'b1);
    check("err_pulse", ERR, 1);
    check("err_idle", BUSY, 0);
    step();
    check("err_one_cycle", ERR, 0);

    // TICK held high 5 clocks with PERIOD=1.
    tick_auto = 1'b0;
    TICK = 1'b0;
    step();
    step();
    start_seq(8'd1, 1'b1);
    TICK = 1'b1;
    nreq = 0; prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) TICK = 1'b0;
      if (REQ && !prev) nreq++;
      prev = REQ;
      ACK  = REQ;
      step();
    end
    ACK = 1'b0;
    check("hold_nreq", nreq, 1);
    check("hold_evt", EVT_CNT, 9);
    stop_seq();
    tick_auto = 1'b1;

    // STOP beats ACK in WAIT_ACK.
    start_seq(8'd1, 1'b0);
    wait_req("stop_req_timeout");
    STOP = 1'b1;
    ACK  = 1'b1;
    step();
    STOP = 1'b0;
    ACK  = 1'b0;
    check("stopack_req", REQ, 0);
    check("stopack_busy", BUSY, 0);
    check("stopack_done", DONE, 0);
    check("stopack_evt", EVT_CNT, 10);
    step();
    check("stopack_done2", DONE, 0);

    // START ignored while BUSY: period must stay 2.
    tick_sampled("ign_align");
    start_seq(8'd2, 1'b1);
    START  = 1'b1;
    PERIOD = 8'd1;
    CONT   = 1'b0;
    step();
    START  = 1'b0;
    tick_sampled("ign_t1");
    check("ign_no_req", REQ, 0);
    tick_sampled("ign_t2");
    check("ign_req", REQ, 1);
    check("ign_evt", EVT_CNT, 11);

    // Asynchronous reset in the middle of a clock period.
    #2;
    RST = 1'b1;
    #1;
    check("async_req", REQ, 0);
    check("async_busy", BUSY, 0);
    check("async_evt", EVT_CNT, 0);
    step();
    RST = 1'b0;
    step();
    check("post_rst_idle", BUSY, 0);

    // Tally wraps 15 -> 0 on the 16th event.
    start_seq(8'd1, 1'b1);
    nreq = 0; prev = 1'b0; cyc = 0;
    while (nreq < 16 && cyc < 200) begin
      if (REQ && !prev) begin
        nreq++;
        if (nreq == 15) check("wrap_15", EVT_CNT, 15);
        if (nreq == 16) check("wrap_0", EVT_CNT, 0);
      end
      prev = REQ;
      ACK  = REQ;
      step();
      cyc++;
    end
    ACK = 1'b0;
    check("wrap_nreq", nreq, 16);
    stop_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
